// File: rtl/lfsr4_seq_checker_if.sv
// Link-side signal bundle for the 4-bit LFSR sequence checker.
// Optional Loss_cnt port is present when LFSR_CHK_LOSS_CNT_EN is defined.
interface lfsr4_seq_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             In_valid;
  logic             In_bit;
  logic             Clr_err;
  logic             Locked;
  logic             Err_pulse;
  logic [ERR_W-1:0] Err_cnt;
`ifdef LFSR_CHK_LOSS_CNT_EN
  logic [3:0]       Loss_cnt;

  modport master (
    output In_valid, In_bit, Clr_err,
    input  Locked, Err_pulse, Err_cnt, Loss_cnt
  );
  modport slave (
    input  In_valid, In_bit, Clr_err,
    output Locked, Err_pulse, Err_cnt, Loss_cnt
  );
`else
  modport master (
    output In_valid, In_bit, Clr_err,
    input  Locked, Err_pulse, Err_cnt
  );
  modport slave (
    input  In_valid, In_bit, Clr_err,
    output Locked, Err_pulse, Err_cnt
  );
`endif
endinterface

// File: rtl/lfsr4_seq_checker.sv
// Self-synchronising checker for the x^4+x^3+1 LFSR stream with lock and error counting.
// Define LFSR_CHK_LOSS_CNT_EN to add the saturating Loss_cnt (lock-loss) output.
module lfsr4_seq_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input logic                 Clk,
  input logic                 Rst,
  lfsr4_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {StSeed, StVerify, StLock} state_e;

  state_e           state_q, state_d;
  logic [3:0]       h_q, h_d;
  logic [2:0]       seed_cnt_q, seed_cnt_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [2:0]       cons_q, cons_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             exp_bit;
  logic             lock_mism;
  logic             lock_lost;
  logic [3:0]       h_shift_in;

  // h[0] is the oldest bit, so the next bit is s[n+1] ^ s[n] = h[1] ^ h[0]
  assign exp_bit    = h_q[1] ^ h_q[0];
  assign h_shift_in = {bus.In_bit, h_q[3:1]};

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    seed_cnt_d  = seed_cnt_q;
    good_cnt_d  = good_cnt_q;
    cons_d      = cons_q;
    err_pulse_d = 1'b0;
    lock_mism   = 1'b0;
    lock_lost   = 1'b0;
    if (bus.In_valid) begin
      unique case (state_q)
        StSeed: begin
          h_d = h_shift_in;
          if (seed_cnt_q == 3'd3) begin
            seed_cnt_d = 3'd0;
            if (h_shift_in != 4'b0000) begin
              state_d    = StVerify;
              good_cnt_d = 4'd0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        StVerify: begin
          h_d = h_shift_in;
          if (bus.In_bit == exp_bit) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_d == 4'(LOCK_CNT)) begin
              state_d = StLock;
              cons_d  = 3'd0;
            end
          end else begin
            state_d    = StSeed;
            seed_cnt_d = 3'd0;
          end
        end
        StLock: begin
          // Track the predicted sequence so a corrupted bit never pollutes history
          h_d = {exp_bit, h_q[3:1]};
          if (bus.In_bit != exp_bit) begin
            lock_mism   = 1'b1;
            err_pulse_d = 1'b1;
            cons_d      = cons_q + 3'd1;
            if (cons_d == 3'(LOSS_CNT)) begin
              lock_lost  = 1'b1;
              state_d    = StSeed;
              seed_cnt_d = 3'd0;
            end
          end else begin
            cons_d = 3'd0;
          end
        end
        default: state_d = StSeed;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.Clr_err) begin
      err_cnt_d = {{(ERR_W-1){1'b0}}, lock_mism};
    end else if (lock_mism && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StSeed;
      h_q         <= 4'b0000;
      seed_cnt_q  <= 3'd0;
      good_cnt_q  <= 4'd0;
      cons_q      <= 3'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      cons_q      <= cons_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.Locked    = (state_q == StLock);
  assign bus.Err_pulse = err_pulse_q;
  assign bus.Err_cnt   = err_cnt_q;

`ifdef LFSR_CHK_LOSS_CNT_EN
  logic [3:0] loss_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      loss_cnt_q <= 4'd0;
    end else if (lock_lost && (loss_cnt_q != 4'd15)) begin
      loss_cnt_q <= loss_cnt_q + 4'd1;
    end
  end

  assign bus.Loss_cnt = loss_cnt_q;
`else
  logic unused_lock_lost;
  assign unused_lock_lost = lock_lost;
`endif

endmodule

// File: tb/tb_lfsr4_seq_checker.sv
// Randomised and directed bench for lfsr4_seq_checker against a queue-based stream model;
// runs an 8-bit and a 2-bit error-counter instance side by side on the same stimulus.
module tb_lfsr4_seq_checker;
  localparam int unsigned LOCK_CNT = 8;
  localparam int unsigned LOSS_CNT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid, bitv, clr;

  lfsr4_seq_checker_if #(.ERR_W(8)) bus8 ();
  lfsr4_seq_checker_if #(.ERR_W(2)) bus2 ();

  assign bus8.In_valid = valid;
  assign bus8.In_bit   = bitv;
  assign bus8.Clr_err  = clr;
  assign bus2.In_valid = valid;
  assign bus2.In_bit   = bitv;
  assign bus2.Clr_err  = clr;

  lfsr4_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(8)) dut8 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus8)
  );
  lfsr4_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) dut2 (
    .Clk (clk),
    .Rst (rst),
    .bus (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int ref_bits [15] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0};
  int ref_idx = 0;

  // Behavioural model: mode 0=seed 1=verify 2=lock; history as a queue of accepted bits
  int m_mode, m_nseed, m_good, m_cons, m_err8, m_err2, m_loss, m_pulse;
  bit hist [$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit b, input bit c, input bit r);
    bit pred, mism, zero;
    int n;
    mism = 0;
    if (r) begin
      m_mode = 0; m_nseed = 0; m_good = 0; m_cons = 0;
      m_err8 = 0; m_err2 = 0; m_loss = 0; m_pulse = 0;
      hist.delete();
      return;
    end
    m_pulse = 0;
    if (v) begin
      n = hist.size();
      pred = (n >= 4) ? (hist[n-4] ^ hist[n-3]) : 1'b0;
      case (m_mode)
        0: begin
          hist.push_back(b);
          m_nseed++;
          if (m_nseed == 4) begin
            m_nseed = 0;
            n = hist.size();
            zero = !(hist[n-1] | hist[n-2] | hist[n-3] | hist[n-4]);
            if (!zero) begin
              m_mode = 1;
              m_good = 0;
            end
          end
        end
        1: begin
          hist.push_back(b);
          if (b == pred) begin
            m_good++;
            if (m_good == LOCK_CNT) begin
              m_mode = 2;
              m_cons = 0;
            end
          end else begin
            m_mode  = 0;
            m_nseed = 0;
          end
        end
        default: begin
          hist.push_back(pred);
          if (b != pred) begin
            mism = 1;
            m_pulse = 1;
            m_cons++;
            if (m_cons == LOSS_CNT) begin
              m_mode  = 0;
              m_nseed = 0;
              if (m_loss < 15) m_loss++;
            end
          end else begin
            m_cons = 0;
          end
        end
      endcase
      while (hist.size() > 8) void'(hist.pop_front());
    end
    if (c) begin
      m_err8 = mism;
      m_err2 = mism;
    end else if (mism) begin
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3) m_err2++;
    end
  endtask

  // Drive one cycle, advance the model on the edge, then compare every output
  task automatic step(input bit v, input bit b, input bit c, input bit r);
    rst = r; valid = v; bitv = b; clr = c;
    @(posedge clk);
    model_step(v, b, c, r);
    #1;
    chk("locked8", int'(bus8.Locked), int'(m_mode == 2));
    chk("locked2", int'(bus2.Locked), int'(m_mode == 2));
    chk("pulse8", int'(bus8.Err_pulse), m_pulse);
    chk("pulse2", int'(bus2.Err_pulse), m_pulse);
    chk("errcnt8", int'(bus8.Err_cnt), m_err8);
    chk("errcnt2", int'(bus2.Err_cnt), m_err2);
`ifdef LFSR_CHK_LOSS_CNT_EN
    chk("losscnt8", int'(bus8.Loss_cnt), m_loss);
    chk("losscnt2", int'(bus2.Loss_cnt), m_loss);
`endif
  endtask

  task automatic ref_bit(input bit inv, input bit c);
    bit b;
    b = ref_bits[ref_idx][0] ^ inv;
    ref_idx = (ref_idx + 1) % 15;
    step(1'b1, b, c, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ref_idx = 0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; bitv = 1'b0; clr = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    do_reset();
    do_reset();
    chk("rst_locked", int'(bus8.Locked), 0);
    chk("rst_pulse", int'(bus8.Err_pulse), 0);
    chk("rst_errcnt", int'(bus8.Err_cnt), 0);

    // Clean lock on the reference stream
    for (int i = 0; i < 45; i++) begin
      ref_bit(1'b0, 1'b0);
      if (i == 10) chk("clean_unlocked_b10", int'(bus8.Locked), 0);
      if (i == 11) chk("clean_locked_b11", int'(bus8.Locked), 1);
    end
    chk("clean_errcnt", int'(bus8.Err_cnt), 0);

    // Single error while locked
    ref_bit(1'b1, 1'b0);
    chk("single_pulse", int'(bus8.Err_pulse), 1);
    chk("single_errcnt", int'(bus8.Err_cnt), 1);
    ref_bit(1'b0, 1'b0);
    chk("single_pulse_drop", int'(bus8.Err_pulse), 0);
    for (int i = 0; i < 14; i++) ref_bit(1'b0, 1'b0);
    chk("single_errcnt_after", int'(bus8.Err_cnt), 1);
    chk("single_still_locked", int'(bus8.Locked), 1);

    // Clear alone
    ref_bit(1'b0, 1'b1);
    chk("clr_alone", int'(bus8.Err_cnt), 0);

    // Lock loss after three consecutive errors, then relock
    for (int i = 0; i < 3; i++) ref_bit(1'b1, 1'b0);
    chk("loss_errcnt", int'(bus8.Err_cnt), 3);
    chk("loss_unlocked", int'(bus8.Locked), 0);
`ifdef LFSR_CHK_LOSS_CNT_EN
    chk("loss_losscnt", int'(bus8.Loss_cnt), 1);
`endif
    for (int i = 0; i < 12; i++) begin
      ref_bit(1'b0, 1'b0);
      if (i == 10) chk("relock_b10", int'(bus8.Locked), 0);
      if (i == 11) chk("relock_b11", int'(bus8.Locked), 1);
    end

    // Valid gaps: lock point counted in accepted bits
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ref_bit(1'b0, 1'b0);
      step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
      if (i == 10) chk("gap_unlocked_b10", int'(bus8.Locked), 0);
      if (i == 11) chk("gap_locked_b11", int'(bus8.Locked), 1);
    end

    // Mismatch during VERIFY returns to SEED without counting an error
    do_reset();
    for (int i = 0; i < 6; i++) ref_bit(1'b0, 1'b0);
    ref_bit(1'b1, 1'b0);
    chk("verify_flip_unlocked", int'(bus8.Locked), 0);
    chk("verify_flip_errcnt", int'(bus8.Err_cnt), 0);
    for (int i = 0; i < 12; i++) ref_bit(1'b0, 1'b0);
    chk("verify_flip_relock", int'(bus8.Locked), 1);

    // All-zero seed is rejected
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    ref_idx = 0;
    for (int i = 0; i < 12; i++) begin
      ref_bit(1'b0, 1'b0);
      if (i == 10) chk("zero_unlocked_b10", int'(bus8.Locked), 0);
      if (i == 11) chk("zero_locked_b11", int'(bus8.Locked), 1);
    end
    chk("zero_errcnt", int'(bus8.Err_cnt), 0);

    // Counter corners: saturation, clear with error, reset mid-lock
    for (int e = 0; e < 5; e++) begin
      ref_bit(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) ref_bit(1'b0, 1'b0);
    end
    chk("sat_errcnt2", int'(bus2.Err_cnt), 3);
    chk("sat_errcnt8", int'(bus8.Err_cnt), 5);
    ref_bit(1'b1, 1'b1);
    chk("clr_with_err8", int'(bus8.Err_cnt), 1);
    chk("clr_with_err2", int'(bus2.Err_cnt), 1);
    chk("clr_keeps_lock", int'(bus8.Locked), 1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst_locked", int'(bus8.Locked), 0);
    chk("midrst_errcnt", int'(bus8.Err_cnt), 0);

    // Randomised traffic on the reference stream with flips, gaps, clears and resets
    ref_idx = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) begin
        do_reset();
      end else if ($urandom_range(3) != 0) begin
        ref_bit(($urandom_range(11) == 0), ($urandom_range(49) == 0));
      end else begin
        step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr4_seq_checker.md
Name: lfsr4_seq_checker

Overview:
- Receive-side checker for the 4-bit LFSR pseudo-random stream. Taps x^4+x^3+1; the serial bit is LFSR bit 0, so s[n+4] = s[n+1] ^ s[n], period 15.
- Self-synchronises from the incoming serial bits, declares lock, then counts bit errors against its own predicted sequence.
- Sits at the far end of a serial link or loopback, for BIST and link test.

Parameters:
- LOCK_CNT, 8: consecutive correct predicted bits needed in VERIFY before Locked asserts (range 1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCK that drop lock (range 1..7).
- ERR_W, 8: width of the saturating error counter.

Ports:
- Clk  input  1  clock; everything is on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- In_valid  input  1  In_bit is sampled this cycle.
- In_bit  input  1  received serial bit.
- Clr_err  input  1  synchronous clear of Err_cnt.
- Locked  output  1  checker is in LOCK state.
- Err_pulse  output  1  one-cycle pulse per mismatch detected in LOCK.
- Err_cnt  output  ERR_W  saturating count of LOCK mismatches.

Behaviour:
- Reset (Rst=1 at an edge):
  - state=SEED, history h[3:0]=0, all counters 0.
  - Locked=0, Err_pulse=0, Err_cnt=0.
  - Rst mid-operation has the same effect and wins over every other input.
- Cycles with In_valid=0 change no state and no counter; Err_pulse=0.
- History: h[0] is the oldest bit. Expected bit e = h[1] ^ h[0]. Each accepted bit shifts in at h[3] (h[2:0] <= h[3:1]).
- SEED:
  - Shift In_bit into h and count accepted bits 0..4.
  - After the 4th bit: if the updated h is 4'b0000 (lockup seed), the seed count returns to 0 and the checker stays in SEED; otherwise go to VERIFY with good count 0.
- VERIFY:
  - Compare In_bit with e and shift In_bit into h.
  - Match: good count +1. When it reaches LOCK_CNT, go to LOCK and set Locked=1 on the same edge.
  - Mismatch: go to SEED, seed count 0. The mismatching bit is discarded and not counted as an error.
- LOCK:
  - Shift e (the predicted bit, not In_bit) into h, so a single corrupted bit cannot corrupt later predictions.
  - Mismatch: Err_pulse=1 for exactly one cycle (registered, the cycle after the bit is accepted); Err_cnt +1; consecutive-error count +1.
  - Match: consecutive-error count cleared to 0.
  - When the consecutive-error count reaches LOSS_CNT, go to SEED with seed count 0 and Locked=0. The LOSS_CNT-th error is still counted and pulsed.
- Err_cnt:
  - Saturates at 2^ERR_W-1; it never wraps.
  - Clr_err alone sets it to 0.
  - Clr_err together with a LOCK mismatch in the same cycle sets it to 1, so the error is not lost.
  - Clr_err does not affect state or Locked.
- Latency: all outputs are registered. Locked and Err_pulse change one clock edge after the deciding In_valid cycle.
- Reference stream from LFSR seed 1001: 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0, repeating.

Optional Feature:
- Macro: LFSR_CHK_LOSS_CNT_EN.
- Defined:
  - Adds output Loss_cnt, 4 bits, reset to 0.
  - Increments on every LOCK->SEED transition and saturates at 15.
  - It is not cleared by Clr_err; only Rst clears it.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Clean lock: Rst, then the reference stream repeated with In_valid=1 continuous, defaults. Locked=0 through bit index 11; Locked=1 after the edge accepting bit 11. Err_cnt stays 0 for 45 bits.
- Zero seed: feed 0,0,0,0, then the reference stream. State stays SEED during the zeros; Locked rises 12 accepted bits after the stream starts; Err_cnt=0.
- Single error in LOCK: invert one bit. Err_pulse=1 for exactly one cycle; Err_cnt=1; Locked stays 1; the following 15 bits give no further errors.
- Lock loss: invert 3 consecutive bits while locked. Err_cnt=3; Locked=0 after the 3rd; with the clean stream resumed, Locked=1 again 12 accepted bits later. With LFSR_CHK_LOSS_CNT_EN defined, Loss_cnt=1.
- Valid gaps / VERIFY mismatch:
  - Reference stream with In_valid alternating 1,0: same lock point counted in accepted bits, and no change on In_valid=0 cycles.
  - A bit flipped during VERIFY returns the checker to SEED with Err_cnt=0.
- Counter corners: ERR_W=2 with 5 isolated errors gives Err_cnt=3 (saturated). Clr_err asserted in the same cycle as an error gives Err_cnt=1; Clr_err alone gives 0. Rst mid-LOCK gives Locked=0 and Err_cnt=0 on the next edge.
